data_mem_lsu: RTL and testbench



---
 rtl/data_mem_lsu.sv | 145 ++++++++++++++
 tb/tb_data_mem_lsu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// Load/store data memory for the single-cycle RISC-V datapath.
// Byte, halfword and word accesses are supported. Loads return sign- or
// zero-extended data one cycle after the request. Misaligned or illegal
// requests are blocked from the array and flagged on the following cycle.
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALU,
  input  logic [31:0] WriteData,
  output logic [31:0] Memoria,
  output logic        MemValid,
  output logic        MisalignErr
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  state_e      r_state;
  logic [31:0] r_memoria;
  logic        r_misalign_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_align_ok;
  logic          w_store_f3_ok;
  logic          w_ld_req;
  logic          w_st_legal;
  logic          w_ld_legal;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rword;
  logic [7:0]    w_rbyte;
  logic [15:0]   w_rhalf;
  logic [31:0]   w_load_ext;
  logic          w_unused_alu;

  // Address bits above the word index are ignored, so accesses wrap.
  assign w_idx        = ALU[AW+1:2];
  assign w_lane       = ALU[1:0];
  assign w_unused_alu = ^ALU[31:AW+2];

  // A simultaneous read and write is treated purely as a store.
  assign w_ld_req = MemRead & ~MemWrite;

  // Size/alignment legality; undefined funct3 codes fall out as illegal.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    w_align_ok = 1'b0;
    unique case (funct3)
      3'b000, 3'b100: w_align_ok = 1'b1;
      3'b001, 3'b101: w_align_ok = ~ALU[0];
      3'b010:         w_align_ok = (ALU[1:0] == 2'b00);
      default:        w_align_ok = 1'b0;
    endcase
  end

  // Unsigned variants exist only for loads.
  assign w_store_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
  assign w_st_legal    = MemWrite & w_align_ok & w_store_f3_ok;
  assign w_ld_legal    = w_ld_req & w_align_ok;
  assign w_err         = (MemWrite & ~w_st_legal) | (w_ld_req & ~w_ld_legal);

  // Byte enables and lane-replicated store data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WriteData;
    unique case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_lane[1], 1'b0};
        w_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
      end
    endcase
  end

  // Array write port with per-byte enables; unselected bytes are preserved.
  // NOTE: the array has no reset branch: clearing it would need a
  // multi-cycle sweep or turn it into flops, and its contents are
  // allowed to be undefined until written.
  always_ff @(posedge clk) begin
    if (w_st_legal) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  // Lane selection and sign/zero extension of the addressed word.
  assign w_rword = r_mem[w_idx];
  assign w_rbyte = 8'(w_rword >> {w_lane, 3'b000});
  assign w_rhalf = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load_ext = w_rword;
    unique case (funct3)
      3'b000:  w_load_ext = {{24{w_rbyte[7]}}, w_rbyte};
      3'b001:  w_load_ext = {{16{w_rhalf[15]}}, w_rhalf};
      3'b100:  w_load_ext = {24'h0, w_rbyte};
      3'b101:  w_load_ext = {16'h0, w_rhalf};
      default: w_load_ext = w_rword;
    endcase
  end

  // Response FSM with registered load data and error pulse.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_memoria      <= 32'h0;
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= w_err;
      if (w_ld_legal) begin
        r_state   <= S_RESP;
        r_memoria <= w_load_ext;
      end else begin
        r_state   <= S_IDLE;
      end
    end
  end

  assign Memoria     = r_memoria;
  assign MemValid    = (r_state == S_RESP);
  assign MisalignErr = r_misalign_err;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed testbench for data_mem_lsu: stores, extended loads, legality
// checks, simultaneous read/write, address wrap and mid-load reset.
`timescale 1ns/1ps
module tb_data_mem_lsu;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALU;
  logic [31:0] WriteData;
  logic [31:0] Memoria;
  logic        MemValid;
  logic        MisalignErr;

  int errors = 0;
  int checks = 0;

  data_mem_lsu #(.DEPTH_WORDS(256), .AW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .funct3      (funct3),
    .ALU         (ALU),
    .WriteData   (WriteData),
    .Memoria     (Memoria),
    .MemValid    (MemValid),
    .MisalignErr (MisalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for one clock; returns #1 after the sampling edge.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    ALU       = addr;
    WriteData = wd;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // One idle cycle; returns #1 after the edge.
  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MemRead = 0; MemWrite = 0; funct3 = 0; ALU = 0; WriteData = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (Memoria !== 32'h0 || MemValid !== 1'b0 || MisalignErr !== 1'b0) begin
      errors++;
      $display("FAIL reset: Memoria=%h MemValid=%b MisalignErr=%b, want 0/0/0", Memoria, MemValid, MisalignErr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw_lw();
    issue(0, 1, F_W, 32'h10, 32'h7FFF_FFFF);
    checks++;
    if (MemValid !== 1'b0) begin
      errors++; $display("FAIL sw_no_valid: MemValid=%b want 0", MemValid);
    end
    issue(1, 0, F_W, 32'h10, 32'h0);
    checks++;
    if (Memoria !== 32'h7FFF_FFFF || MemValid !== 1'b1) begin
      errors++; $display("FAIL lw_basic: Memoria=%h MemValid=%b want 7fffffff/1", Memoria, MemValid);
    end
    idle_cycle();
    checks++;
    if (MemValid !== 1'b0 || Memoria !== 32'h7FFF_FFFF) begin
      errors++; $display("FAIL lw_pulse: MemValid=%b Memoria=%h want 0/7fffffff", MemValid, Memoria);
    end
  endtask

  task automatic test_byte_store();
    issue(0, 1, F_W, 32'h20, 32'h1234_5678);
    issue(0, 1, F_B, 32'h21, 32'h0000_00AA);
    issue(1, 0, F_W, 32'h20, 32'h0);
    checks++;
    if (Memoria !== 32'h1234_AA78) begin
      errors++; $display("FAIL sb_merge: Memoria=%h want 1234aa78", Memoria);
    end
    issue(0, 1, F_H, 32'h22, 32'hBEEF_C0DE);
    issue(1, 0, F_W, 32'h20, 32'h0);
    checks++;
    if (Memoria !== 32'hC0DE_AA78) begin
      errors++; $display("FAIL sh_merge: Memoria=%h want c0deaa78", Memoria);
    end
    issue(0, 1, F_W, 32'h20, 32'h1234_AA78);
  endtask

  task automatic test_extend();
    logic [2:0]  f3_tab  [5];
    logic [31:0] adr_tab [5];
    logic [31:0] exp_tab [5];
    f3_tab  = '{F_B,          F_BU,         F_H,          F_HU,         F_B};
    adr_tab = '{32'h30,       32'h30,       32'h30,       32'h32,       32'h31};
    exp_tab = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80, 32'h00000000, 32'hFFFFFFFF};
    issue(0, 1, F_W, 32'h30, 32'h0000_FF80);
    for (int i = 0; i < 5; i++) begin
      issue(1, 0, f3_tab[i], adr_tab[i], 32'h0);
      checks++;
      if (Memoria !== exp_tab[i] || MemValid !== 1'b1) begin
        errors++;
        $display("FAIL extend[%0d]: Memoria=%h MemValid=%b want %h/1", i, Memoria, MemValid, exp_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    seq = '{32'h10, 32'h20, 32'h30};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; funct3 = F_W; ALU = seq[i];
      @(posedge clk);
      #1;
      checks++;
      if (MemValid !== 1'b1 || Memoria !== (i == 0 ? 32'h7FFF_FFFF : i == 1 ? 32'h1234_AA78 : 32'h0000_FF80)) begin
        errors++; $display("FAIL b2b[%0d]: Memoria=%h MemValid=%b", i, Memoria, MemValid);
      end
    end
    MemRead = 1'b0;
  endtask

  task automatic test_misalign();
    issue(1, 0, F_HU, 32'h32, 32'h0);
    issue(1, 0, F_W, 32'h31, 32'h0);
    checks++;
    if (MisalignErr !== 1'b1 || MemValid !== 1'b0 || Memoria !== 32'h0) begin
      errors++; $display("FAIL lw_misalign: err=%b valid=%b Memoria=%h want 1/0/0", MisalignErr, MemValid, Memoria);
    end
    idle_cycle();
    checks++;
    if (MisalignErr !== 1'b0) begin
      errors++; $display("FAIL err_pulse: MisalignErr=%b want 0", MisalignErr);
    end
    issue(0, 1, F_H, 32'h33, 32'h1111_2222);
    checks++;
    if (MisalignErr !== 1'b1 || Memoria !== 32'h0) begin
      errors++; $display("FAIL sh_misalign: err=%b Memoria=%h want 1/0", MisalignErr, Memoria);
    end
    issue(0, 1, F_BU, 32'h30, 32'h0000_0011);
    checks++;
    if (MisalignErr !== 1'b1) begin
      errors++; $display("FAIL st_f3_illegal: err=%b want 1", MisalignErr);
    end
    issue(1, 0, 3'b011, 32'h30, 32'h0);
    checks++;
    if (MisalignErr !== 1'b1 || MemValid !== 1'b0) begin
      errors++; $display("FAIL ld_f3_illegal: err=%b valid=%b want 1/0", MisalignErr, MemValid);
    end
    issue(1, 0, F_W, 32'h30, 32'h0);
    checks++;
    if (Memoria !== 32'h0000_FF80 || MisalignErr !== 1'b0) begin
      errors++; $display("FAIL word30_intact: Memoria=%h err=%b want 0000ff80/0", Memoria, MisalignErr);
    end
  endtask

  task automatic test_wrap_rw();
    issue(0, 1, F_W, 32'h400, 32'h5555_5555);
    issue(1, 0, F_W, 32'h000, 32'h0);
    checks++;
    if (Memoria !== 32'h5555_5555) begin
      errors++; $display("FAIL wrap: Memoria=%h want 55555555", Memoria);
    end
    issue(1, 1, F_W, 32'h40, 32'hFFFF_0000);
    checks++;
    if (MemValid !== 1'b0 || MisalignErr !== 1'b0 || Memoria !== 32'h5555_5555) begin
      errors++; $display("FAIL rw_both: valid=%b err=%b Memoria=%h want 0/0/55555555", MemValid, MisalignErr, Memoria);
    end
    issue(1, 0, F_W, 32'h40, 32'h0);
    checks++;
    if (Memoria !== 32'hFFFF_0000) begin
      errors++; $display("FAIL rw_stored: Memoria=%h want ffff0000", Memoria);
    end
  endtask

  task automatic test_reset_midload();
    issue(1, 0, F_W, 32'h10, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Memoria !== 32'h0 || MemValid !== 1'b0 || MisalignErr !== 1'b0) begin
      errors++; $display("FAIL midload_reset: Memoria=%h valid=%b err=%b want 0/0/0", Memoria, MemValid, MisalignErr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 0, F_W, 32'h20, 32'h0);
    checks++;
    if (Memoria !== 32'h1234_AA78 || MemValid !== 1'b1) begin
      errors++; $display("FAIL retain20: Memoria=%h valid=%b want 1234aa78/1", Memoria, MemValid);
    end
    issue(1, 0, F_W, 32'h40, 32'h0);
    checks++;
    if (Memoria !== 32'hFFFF_0000) begin
      errors++; $display("FAIL retain40: Memoria=%h want ffff0000", Memoria);
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte_store();
    test_extend();
    test_back_to_back();
    test_misalign();
    test_wrap_rw();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
